if_id_imm_buffer: RTL

Fetch/decode pipeline register between the instruction fetch stage and the decode stage. Registers the fetched instruction word, its PC and PC+1, and assembles two-word instructions (opcode word + 16-bit immediate word) into one decode bundle. Drives the immediate-pending flag back to fetch, so fetch substitutes a NOP for the immediate word on its instruction path. Supports stall (hold) and flush (bubble insert) from the hazard/branch logic.

---
 rtl/if_id_imm_buffer_if.sv | 64 ++++++
 rtl/if_id_imm_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/if_id_imm_buffer_if.sv
// ---------------------------------------------------------------------------
// if_id_imm_buffer_if
//
// Purpose: groups the fetch-side inputs and decode-side outputs of the
// IF/ID immediate-assembly buffer into one bundle.
//
// Signals:
//   instr_in      16  instruction word from fetch (after fetch's NOP mux)
//   raw_word_in   16  unmuxed instruction-memory word, source of the immediate
//   pc_in         32  PC of the word being fetched
//   pc_plus1_in   32  PC+1 from the fetch adder
//   stall          1  hold all buffer state
//   flush          1  drop current and pending contents
//   instr_out     16  opcode word to decode
//   imm_out       16  immediate of a two-word instruction
//   imm_valid      1  imm_out belongs to instr_out
//   pc_out        32  PC of instr_out's opcode word
//   pc_plus1_out  32  PC following the complete instruction
//   valid_out      1  instr_out is a real instruction, not a bubble
//   imm_pending    1  back to fetch: waiting for the immediate word
//   bubble_count  16  bubble counter (only with IF_ID_BUBBLE_COUNT_EN)
//
// Modports:
//   master  fetch/hazard side (drives inputs, observes outputs)
//   slave   the buffer itself
//
// Optional feature macro: IF_ID_BUBBLE_COUNT_EN
// ---------------------------------------------------------------------------
interface if_id_imm_buffer_if;
    logic [15:0] instr_in;
    logic [15:0] raw_word_in;
    logic [31:0] pc_in;
    logic [31:0] pc_plus1_in;
    logic        stall;
    logic        flush;
    logic [15:0] instr_out;
    logic [15:0] imm_out;
    logic        imm_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus1_out;
    logic        valid_out;
    logic        imm_pending;
`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [15:0] bubble_count;
`endif

    modport master (
        output instr_in, raw_word_in, pc_in, pc_plus1_in, stall, flush,
        input  instr_out, imm_out, imm_valid, pc_out, pc_plus1_out,
               valid_out, imm_pending
`ifdef IF_ID_BUBBLE_COUNT_EN
        , input bubble_count
`endif
    );

    modport slave (
        input  instr_in, raw_word_in, pc_in, pc_plus1_in, stall, flush,
        output instr_out, imm_out, imm_valid, pc_out, pc_plus1_out,
               valid_out, imm_pending
`ifdef IF_ID_BUBBLE_COUNT_EN
        , output bubble_count
`endif
    );
endinterface

// File: rtl/if_id_imm_buffer.sv
// ---------------------------------------------------------------------------
// if_id_imm_buffer
//
// Purpose: IF/ID pipeline register. Registers the fetched instruction, its
// PC and PC+1, and merges a two-word instruction (opcode word with bit 0 set,
// followed by a 16-bit immediate word) into a single decode bundle. While the
// immediate is outstanding, imm_pending tells fetch to put a NOP on its
// instruction path; the immediate itself is taken from raw_word_in.
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of if_id_imm_buffer_if (fetch inputs, decode outputs)
//
// Parameters:
//   NOP_WORD  instruction word emitted on bubbles
//
// Optional feature macro: IF_ID_BUBBLE_COUNT_EN adds a saturating 16-bit
// count of bubbles loaded on non-stalled edges (flush or opcode latch).
//
// Edge priority: rst > flush > stall > normal update. All outputs are
// registered.
// ---------------------------------------------------------------------------
module if_id_imm_buffer #(
    parameter logic [15:0] NOP_WORD = 16'h5000
) (
    input  logic              clk,
    input  logic              rst,
    if_id_imm_buffer_if.slave bus
);

    typedef enum logic {
        NORM = 1'b0,
        IMM  = 1'b1
    } state_t;

    state_t      state_q,        state_d;
    logic [15:0] held_instr_q,   held_instr_d;
    logic [31:0] held_pc_q,      held_pc_d;
    logic [15:0] instr_out_q,    instr_out_d;
    logic [15:0] imm_out_q,      imm_out_d;
    logic        imm_valid_q,    imm_valid_d;
    logic [31:0] pc_out_q,       pc_out_d;
    logic [31:0] pc_plus1_out_q, pc_plus1_out_d;
    logic        valid_out_q,    valid_out_d;
    logic        load_bubble;

`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [15:0] bubble_count_q, bubble_count_d;
`endif

    // State register: reset first, otherwise take the next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= NORM;
            held_instr_q   <= '0;
            held_pc_q      <= '0;
            instr_out_q    <= NOP_WORD;
            imm_out_q      <= '0;
            imm_valid_q    <= 1'b0;
            pc_out_q       <= '0;
            pc_plus1_out_q <= '0;
            valid_out_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            held_instr_q   <= held_instr_d;
            held_pc_q      <= held_pc_d;
            instr_out_q    <= instr_out_d;
            imm_out_q      <= imm_out_d;
            imm_valid_q    <= imm_valid_d;
            pc_out_q       <= pc_out_d;
            pc_plus1_out_q <= pc_plus1_out_d;
            valid_out_q    <= valid_out_d;
        end
    end

    // Next-state logic. Defaults hold everything, which is exactly the stall
    // behaviour; flush overrides stall. A bubble keeps the PC outputs as they
    // were since decode ignores them when valid_out is low.
    always_comb begin
        state_d        = state_q;
        held_instr_d   = held_instr_q;
        held_pc_d      = held_pc_q;
        instr_out_d    = instr_out_q;
        imm_out_d      = imm_out_q;
        imm_valid_d    = imm_valid_q;
        pc_out_d       = pc_out_q;
        pc_plus1_out_d = pc_plus1_out_q;
        valid_out_d    = valid_out_q;
        load_bubble    = 1'b0;

        if (bus.flush) begin
            load_bubble  = 1'b1;
            state_d      = NORM;
            held_instr_d = '0;
            held_pc_d    = '0;
            instr_out_d  = NOP_WORD;
            imm_out_d    = '0;
            imm_valid_d  = 1'b0;
            valid_out_d  = 1'b0;
        end else if (!bus.stall) begin
            unique case (state_q)
                NORM: begin
                    if (bus.instr_in[0]) begin
                        // Opcode of a two-word instruction: park it and
                        // emit a bubble while the immediate arrives.
                        load_bubble  = 1'b1;
                        state_d      = IMM;
                        held_instr_d = bus.instr_in;
                        held_pc_d    = bus.pc_in;
                        instr_out_d  = NOP_WORD;
                        imm_out_d    = '0;
                        imm_valid_d  = 1'b0;
                        valid_out_d  = 1'b0;
                    end else begin
                        instr_out_d    = bus.instr_in;
                        pc_out_d       = bus.pc_in;
                        pc_plus1_out_d = bus.pc_plus1_in;
                        imm_out_d      = '0;
                        imm_valid_d    = 1'b0;
                        valid_out_d    = 1'b1;
                    end
                end
                IMM: begin
                    // The incoming word is the immediate, never an opcode.
                    // pc_plus1_in now points past the immediate, which is
                    // the correct return address for the whole instruction.
                    state_d        = NORM;
                    instr_out_d    = held_instr_q;
                    pc_out_d       = held_pc_q;
                    pc_plus1_out_d = bus.pc_plus1_in;
                    imm_out_d      = bus.raw_word_in;
                    imm_valid_d    = 1'b1;
                    valid_out_d    = 1'b1;
                end
                default: state_d = NORM;
            endcase
        end
    end

`ifdef IF_ID_BUBBLE_COUNT_EN
    // Bubble counter: saturates at all-ones, cleared only by reset.
    always_comb begin
        bubble_count_d = bubble_count_q;
        if (load_bubble && (bubble_count_q != 16'hFFFF)) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_count_q <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.bubble_count = bubble_count_q;
`else
    logic unused_bubble;
    assign unused_bubble = load_bubble;
`endif

    assign bus.instr_out    = instr_out_q;
    assign bus.imm_out      = imm_out_q;
    assign bus.imm_valid    = imm_valid_q;
    assign bus.pc_out       = pc_out_q;
    assign bus.pc_plus1_out = pc_plus1_out_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.imm_pending  = (state_q == IMM);

endmodule
